// File: rtl/psk_pkg.sv
// Shared constants and types for the coherent BPSK demodulator.
package psk_pkg;

    localparam int SAMPLE_W = 8;
    localparam logic [SAMPLE_W-1:0] SAMPLE_ZERO = 8'd128;
    localparam int PHASE_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Smallest integrator that cannot overflow: 9-bit product magnitude, SYM_LEN terms, one guard bit.
    function automatic int min_acc_w(input int sym_len);
        return 9 + $clog2(sym_len) + 1;
    endfunction

endpackage

// File: rtl/psk_int_dump.sv
// Signed integrate-and-dump: accumulates products over one symbol, clears on dump, reloads on sync restart.
module psk_int_dump
    import psk_pkg::*;
#(
    parameter int SYM_LEN = 256,
    parameter int ACC_W   = 22
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [ACC_W-1:0] prod,
    input  logic                    restart,
    input  logic                    step,
    output logic signed [ACC_W-1:0] sum,
    output logic                    last
);

    localparam int CNT_W = $clog2(SYM_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_LEN - 1);

    logic signed [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0]        cnt_r;

    assign sum  = acc_r + prod;
    assign last = (cnt_r == CNT_LAST);

    // Restart outranks a coincident end-of-symbol so a resync always opens a fresh symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
            cnt_r <= '0;
        end else if (restart) begin
            acc_r <= prod;
            cnt_r <= CNT_W'(1'b1);
        end else if (step) begin
            if (last) begin
                acc_r <= '0;
                cnt_r <= '0;
            end else begin
                acc_r <= sum;
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/psk_demod.sv
// Coherent BPSK demodulator: local carrier phase, sign-multiply, integrate-and-dump, hard decision.
// Define DIFF_DECODE_EN for differential (DPSK) decoding of the raw decisions.
module psk_demod
    import psk_pkg::*;
#(
    parameter int SYM_LEN = 256,
    parameter int LUT_LAT = 1,
    parameter int ACC_W   = 22
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    N,
    input  logic [SAMPLE_W-1:0]     din_PSK,
    input  logic                    din_vld,
    input  logic                    sym_sync,
    output logic                    bit_out,
    output logic                    bit_vld,
    output logic signed [ACC_W-1:0] acc_out
);

    if (ACC_W < min_acc_w(SYM_LEN) || SYM_LEN < 2 || SYM_LEN > 4096 || LUT_LAT < 0 || LUT_LAT > 3)
    begin : g_param_check
        $error("psk_demod: illegal parameters (ACC_W too small or SYM_LEN/LUT_LAT out of range)");
    end

    logic [PHASE_W-1:0]      phase_r;
    logic                    sign_now_s;
    logic                    sign_al_s;
    logic signed [SAMPLE_W:0] s_s;
    logic signed [ACC_W-1:0] s_ext_s;
    logic signed [ACC_W-1:0] prod_s;
    logic signed [ACC_W-1:0] sum_s;
    logic                    last_s;
    logic                    restart_s;
    logic                    step_s;
    logic                    dump_s;
    logic                    clr_prev_s;
    logic                    raw_s;
    logic                    dec_s;
    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    bit_out_r;
    logic                    bit_vld_r;
    logic signed [ACC_W-1:0] acc_out_r;

    // Free-running carrier phase, same step rule as the modulator address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= '0;
        end else begin
            phase_r <= phase_r + PHASE_W'(N) + PHASE_W'(1'b1);
        end
    end

    assign sign_now_s = ~phase_r[PHASE_W-1];

    if (LUT_LAT == 0) begin : g_no_dly
        assign sign_al_s = sign_now_s;
    end else begin : g_dly
        logic [LUT_LAT-1:0] sign_dly_r;

        // Sign delay line matching the modulator's LUT read latency.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sign_dly_r <= '0;
            end else begin
                sign_dly_r[0] <= sign_now_s;
                for (int i = 1; i < LUT_LAT; i++) begin
                    sign_dly_r[i] <= sign_dly_r[i-1];
                end
            end
        end

        assign sign_al_s = sign_dly_r[LUT_LAT-1];
    end

    assign s_s     = $signed({1'b0, din_PSK}) - $signed({1'b0, SAMPLE_ZERO});
    assign s_ext_s = ACC_W'(s_s);
    assign prod_s  = sign_al_s ? s_ext_s : -s_ext_s;

    psk_int_dump #(
        .SYM_LEN (SYM_LEN),
        .ACC_W   (ACC_W)
    ) u_int_dump (
        .clk     (clk),
        .rst_n   (rst_n),
        .prod    (prod_s),
        .restart (restart_s),
        .step    (step_s),
        .sum     (sum_s),
        .last    (last_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (sym_sync && din_vld) begin
                    state_nxt_s = TRACK;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            TRACK:   state_nxt_s = TRACK;
            default: state_nxt_s = IDLE;
        endcase
    end

    always_comb begin
        restart_s  = sym_sync & din_vld;
        step_s     = 1'b0;
        dump_s     = 1'b0;
        clr_prev_s = 1'b0;
        case (state_r)
            IDLE: begin
                clr_prev_s = restart_s;
            end
            TRACK: begin
                step_s = din_vld & ~restart_s;
                dump_s = din_vld & ~restart_s & last_s;
            end
            default: begin
                step_s = 1'b0;
            end
        endcase
    end

    assign raw_s = sum_s[ACC_W-1];

`ifdef DIFF_DECODE_EN
    logic prev_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b0;
        end else if (clr_prev_s) begin
            prev_r <= 1'b0;
        end else if (dump_s) begin
            prev_r <= raw_s;
        end else begin
            prev_r <= prev_r;
        end
    end

    assign dec_s = raw_s ^ prev_r;
`else
    assign dec_s = raw_s;
`endif

    // Decision register: a negative integral means the carrier was inverted; zero decides 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_vld_r <= 1'b0;
            bit_out_r <= 1'b0;
            acc_out_r <= '0;
        end else begin
            bit_vld_r <= dump_s;
            if (dump_s) begin
                bit_out_r <= dec_s;
                acc_out_r <= sum_s;
            end else begin
                bit_out_r <= bit_out_r;
                acc_out_r <= acc_out_r;
            end
        end
    end

    assign bit_out = bit_out_r;
    assign bit_vld = bit_vld_r;
    assign acc_out = acc_out_r;

endmodule
